// File: rtl/regfile_read_stage.sv
// Register-file read stage: handshaked source-address request, same-edge write-back bypass,
// hardwired-zero register, and a one-entry output register that snoops write-back while held.
module regfile_read_stage #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-1:0] in_rs1_i,
  input  logic [ADDR_WIDTH-1:0] in_rs2_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr1_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr2_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata1_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata2_i,
  input  logic                  wb_wen_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_rs1_o,
  output logic [ADDR_WIDTH-1:0] out_rs2_o,
  output logic [DATA_WIDTH-1:0] out_src1_o,
  output logic [DATA_WIDTH-1:0] out_src2_o
);

  // state | meaning
  // EMPTY | no operands held, out_valid low
  // FULL  | operand pair held for execute, out_valid high
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic                    accept;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // The register file commits on the same edge we capture, so its read data is one write behind.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic                  wen,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    if (is_zero(addr))                return '0;
    else if (wen && (waddr == addr))  return wdata;
    else                              return rdata;
  endfunction

  assign in_ready_o  = (state_q == EMPTY) || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign rf_raddr1_o = in_rs1_i;
  assign rf_raddr2_o = in_rs2_i;

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    src1_d  = src1_q;
    src2_d  = src2_q;

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      rs1_d  = in_rs1_i;
      rs2_d  = in_rs2_i;
      src1_d = resolve(in_rs1_i, rf_rdata1_i, wb_wen_i, wb_waddr_i, wb_wdata_i);
      src2_d = resolve(in_rs2_i, rf_rdata2_i, wb_wen_i, wb_waddr_i, wb_wdata_i);
    end else if (state_q == FULL) begin
      // Snoop keeps a held operand current; on a drain cycle the update is simply discarded.
      if (wb_wen_i && (wb_waddr_i == rs1_q) && !is_zero(rs1_q)) src1_d = wb_wdata_i;
      if (wb_wen_i && (wb_waddr_i == rs2_q) && !is_zero(rs2_q)) src2_d = wb_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rs1_q   <= '0;
      rs2_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_rs1_o   = rs1_q;
  assign out_rs2_o   = rs2_q;
  assign out_src1_o  = src1_q;
  assign out_src2_o  = src2_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: vector table for single-shot captures, plus
// hand-written reset, backpressure-snoop, streaming and drain sequences.
module tb_regfile_read_stage;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_rs1, in_rs2, rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          wb_wen;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_rs1, out_rs2;
  logic [DW-1:0] out_src1, out_src2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_read_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
    .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
    .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
    .out_src1_o(out_src1), .out_src2_o(out_src2)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2;
    logic [DW-1:0] rd1, rd2;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp1, exp2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    in_valid  = v;
    in_rs1    = r1;
    in_rs2    = r2;
    rf_rdata1 = d1;
    rf_rdata2 = d2;
  endtask

  task automatic wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_wen   = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    vecs[0] = '{rs1: 5'd3,  rs2: 5'd4,  rd1: 32'h11111111, rd2: 32'h22222222, wen: 1'b0, waddr: 5'd0,  wdata: 32'h0,
                exp1: 32'h11111111, exp2: 32'h22222222};
    vecs[1] = '{rs1: 5'd5,  rs2: 5'd0,  rd1: 32'h0,        rd2: 32'h00000055, wen: 1'b1, waddr: 5'd5,  wdata: 32'hDEADBEEF,
                exp1: 32'hDEADBEEF, exp2: 32'h0};
    vecs[2] = '{rs1: 5'd0,  rs2: 5'd9,  rd1: 32'h00000077, rd2: 32'h00000099, wen: 1'b1, waddr: 5'd0,  wdata: 32'h00001234,
                exp1: 32'h0,        exp2: 32'h00000099};
    vecs[3] = '{rs1: 5'd6,  rs2: 5'd6,  rd1: 32'h00000066, rd2: 32'h00000066, wen: 1'b1, waddr: 5'd6,  wdata: 32'hCAFEF00D,
                exp1: 32'hCAFEF00D, exp2: 32'hCAFEF00D};
    vecs[4] = '{rs1: 5'd10, rs2: 5'd11, rd1: 32'h0000000A, rd2: 32'h0000000B, wen: 1'b1, waddr: 5'd12, wdata: 32'h0000FFFF,
                exp1: 32'h0000000A, exp2: 32'h0000000B};
    vecs[5] = '{rs1: 5'd31, rs2: 5'd12, rd1: 32'h0000001F, rd2: 32'h0000000C, wen: 1'b1, waddr: 5'd12, wdata: 32'h0BADCAFE,
                exp1: 32'h0000001F, exp2: 32'h0BADCAFE};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    wb(1'b0, '0, '0);
    #12;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset_src1", out_src1, 32'h0);
    chk("reset_src2", out_src2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table vectors: each accepted with out_ready high, checked one cycle later.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd1, vecs[i].rd2);
      wb(vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_raddr1", i), {27'b0, rf_raddr1}, {27'b0, vecs[i].rs1});
      chk($sformatf("v%0d_raddr2", i), {27'b0, rf_raddr2}, {27'b0, vecs[i].rs2});
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_rs1", i), {27'b0, out_rs1}, {27'b0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2", i), {27'b0, out_rs2}, {27'b0, vecs[i].rs2});
      chk($sformatf("v%0d_src1", i), out_src1, vecs[i].exp1);
      chk($sformatf("v%0d_src2", i), out_src2, vecs[i].exp2);
    end

    // Backpressure with write-back snoop on the held entry.
    drive(1'b1, 5'd7, 5'd8, 32'h1, 32'h2);
    wb(1'b0, '0, '0);
    step();
    chk("snoop_cap_src1", out_src1, 32'h1);
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 5'd10, 32'h9, 32'hA);
    #1;
    chk("snoop_c1_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("snoop_c1_rs1", {27'b0, out_rs1}, 32'd7);
    chk("snoop_c1_src1", out_src1, 32'h1);
    wb(1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    chk("snoop_c2_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("snoop_c2_src1", out_src1, 32'hA5A5A5A5);
    chk("snoop_c2_src2", out_src2, 32'h2);
    wb(1'b0, '0, '0);
    step();
    chk("snoop_c3_src1", out_src1, 32'hA5A5A5A5);
    chk("snoop_c3_rs1", {27'b0, out_rs1}, 32'd7);
    chk("snoop_c3_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("snoop_release_rs1", {27'b0, out_rs1}, 32'd9);
    chk("snoop_release_src1", out_src1, 32'h9);

    // Streaming 1..8 with no bubbles.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, AW'(i), AW'(i + 16), DW'(i * 256), DW'(i));
      step();
      chk($sformatf("stream%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_rs1", i), {27'b0, out_rs1}, DW'(i));
      chk($sformatf("stream%0d_src1", i), out_src1, DW'(i * 256));
    end
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 5'd25, 32'h900, 32'h9);
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("stall_rs1_held", {27'b0, out_rs1}, 32'd8);
    out_ready = 1'b1;
    step();
    chk("stall_resume_rs1", {27'b0, out_rs1}, 32'd9);
    chk("stall_resume_valid", {31'b0, out_valid}, 32'd1);

    // Drain: no new request, entry leaves, registers keep their contents.
    drive(1'b0, 5'd3, 5'd3, 32'hBAD0BAD0, 32'hBAD0BAD0);
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_rs1", {27'b0, out_rs1}, 32'd9);
    chk("drain_src1", out_src1, 32'h900);
    step();
    chk("idle_src1_hold", out_src1, 32'h900);

    // Asynchronous reset while FULL, asserted mid-cycle.
    drive(1'b1, 5'd2, 5'd3, 32'h12345678, 32'h87654321);
    step();
    chk("prereset_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_src1", out_src1, 32'h0);
    chk("async_rst_src2", out_src2, 32'h0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
